// File: rtl/iq_window_integrator_if.sv
// rtl/iq_window_integrator_if.sv - sample-in / IQ-result-out bundle for iq_window_integrator
//
// Signals:
//   sample_valid, sample, lo_cos, lo_sin : ADC sample and LO words, qualified by sample_valid
//   iq_valid, i_val, q_val               : one-cycle result strobe and held signed 32-bit I/Q
// Modports:
//   master : sample producer / result consumer
//   slave  : the integrator
interface iq_window_integrator_if #(
    parameter int SAMPLE_W = 16,
    parameter int LO_W     = 16
);
    logic                       sample_valid;
    logic signed [SAMPLE_W-1:0] sample;
    logic signed [LO_W-1:0]     lo_cos;
    logic signed [LO_W-1:0]     lo_sin;
    logic                       iq_valid;
    logic signed [31:0]         i_val;
    logic signed [31:0]         q_val;

    modport master (
        output sample_valid, sample, lo_cos, lo_sin,
        input  iq_valid, i_val, q_val
    );

    modport slave (
        input  sample_valid, sample, lo_cos, lo_sin,
        output iq_valid, i_val, q_val
    );
endinterface

// File: rtl/iq_window_integrator.sv
// rtl/iq_window_integrator.sv - LO demodulation and triggered boxcar IQ integration
//
// Ports:
//   clk100, reset        : clock, synchronous active-high reset (priority over everything)
//   trigger              : start-of-readout pulse, accepted only in IDLE
//   int_delay, int_len   : valid samples skipped / integrated, latched on trigger
//   iq (slave)           : sample stream in, iq_valid/i_val/q_val out
//   busy                 : window in progress
//   missed_trig          : saturating count of triggers ignored outside IDLE
//   i_offset, q_offset   : signed offsets subtracted at the output (IQ_OFFSET_CORR_EN only)
// Build option: IQ_OFFSET_CORR_EN adds the offset ports and one saturating output stage.
module iq_window_integrator #(
    parameter int SAMPLE_W = 16,
    parameter int LO_W     = 16,
    parameter int LEN_W    = 12
) (
    input  logic                 clk100,
    input  logic                 reset,
    input  logic                 trigger,
    input  logic [LEN_W-1:0]     int_delay,
    input  logic [LEN_W-1:0]     int_len,
`ifdef IQ_OFFSET_CORR_EN
    input  logic signed [31:0]   i_offset,
    input  logic signed [31:0]   q_offset,
`endif
    iq_window_integrator_if.slave iq,
    output logic                 busy,
    output logic [7:0]           missed_trig
);
    localparam int PROD_W = SAMPLE_W + LO_W;
    localparam int PI_W   = SAMPLE_W + 1;
    localparam int ACC_W  = SAMPLE_W + LEN_W + 1;

    if (SAMPLE_W + LEN_W + 1 > 32) begin : g_width_check
        $error("iq_window_integrator: SAMPLE_W+LEN_W+1 must not exceed 32");
    end

    typedef enum logic [2:0] {ST_IDLE, ST_DELAY, ST_INTEGRATE, ST_FLUSH, ST_OUTPUT} state_t;

    state_t                    state_q, state_d;
    logic [LEN_W-1:0]          dly_q, dly_d, len_q, len_d;
    logic [LEN_W-1:0]          dcnt_q, dcnt_d, icnt_q, icnt_d;
    logic                      flush_q, flush_d;
    logic signed [PI_W-1:0]    pi_q, pi_d, pq_q, pq_d;
    logic                      s1v_q, s1v_d;
    logic signed [ACC_W-1:0]   acc_i_q, acc_i_d, acc_q_q, acc_q_d;
    logic                      busy_q, busy_d, iq_valid_q, iq_valid_d;
    logic signed [31:0]        i_val_q, i_val_d, q_val_q, q_val_d;
    logic [7:0]                missed_q, missed_d;
`ifdef IQ_OFFSET_CORR_EN
    logic signed [33:0]        di_q, di_d, dq_q, dq_d;
    logic                      ost_q, ost_d;

    function automatic logic signed [31:0] sat32(input logic signed [33:0] v);
        if (v[33:31] == 3'b000 || v[33:31] == 3'b111) return v[31:0];
        else if (v[33]) return 32'sh8000_0000;
        else return 32'sh7FFF_FFFF;
    endfunction
`endif

    logic signed [PROD_W-1:0]  prod_i, prod_q;
    logic [LEN_W-1:0]          dcnt_inc, icnt_inc;
    logic                      unused_bits;

    assign prod_i   = PROD_W'(iq.sample) * PROD_W'(iq.lo_cos);
    assign prod_q   = PROD_W'(iq.sample) * PROD_W'(iq.lo_sin);
    assign dcnt_inc = dcnt_q + LEN_W'(1);
    assign icnt_inc = icnt_q + LEN_W'(1);
    // Dropping the low LO_W-1 bits of a signed product is an arithmetic shift (floor).
    assign unused_bits = ^{prod_i[LO_W-2:0], prod_q[LO_W-2:0]};

    always_comb begin
        state_d    = state_q;
        dly_d      = dly_q;
        len_d      = len_q;
        dcnt_d     = dcnt_q;
        icnt_d     = icnt_q;
        flush_d    = flush_q;
        pi_d       = pi_q;
        pq_d       = pq_q;
        s1v_d      = 1'b0;
        acc_i_d    = acc_i_q;
        acc_q_d    = acc_q_q;
        busy_d     = busy_q;
        iq_valid_d = 1'b0;
        i_val_d    = i_val_q;
        q_val_d    = q_val_q;
        missed_d   = missed_q;
`ifdef IQ_OFFSET_CORR_EN
        di_d       = di_q;
        dq_d       = dq_q;
        ost_d      = ost_q;
`endif
        if (s1v_q) begin
            acc_i_d = acc_i_q + {{LEN_W{pi_q[PI_W-1]}}, pi_q};
            acc_q_d = acc_q_q + {{LEN_W{pq_q[PI_W-1]}}, pq_q};
        end
        if (trigger && state_q != ST_IDLE && missed_q != 8'hFF) begin
            missed_d = missed_q + 8'd1;
        end
        unique case (state_q)
            ST_IDLE: begin
                if (trigger) begin
                    dly_d   = int_delay;
                    len_d   = int_len;
                    dcnt_d  = '0;
                    icnt_d  = '0;
                    acc_i_d = '0;
                    acc_q_d = '0;
                    busy_d  = 1'b1;
                    state_d = ST_DELAY;
                end
            end
            ST_DELAY: begin
                // A zero delay leaves on the first edge regardless of sample_valid.
                if (dcnt_q == dly_q || (iq.sample_valid && dcnt_inc == dly_q)) begin
                    state_d = (len_q == '0) ? ST_FLUSH : ST_INTEGRATE;
                    flush_d = 1'b0;
                end else if (iq.sample_valid) begin
                    dcnt_d = dcnt_inc;
                end
            end
            ST_INTEGRATE: begin
                if (iq.sample_valid) begin
                    pi_d   = prod_i[PROD_W-1:LO_W-1];
                    pq_d   = prod_q[PROD_W-1:LO_W-1];
                    s1v_d  = 1'b1;
                    icnt_d = icnt_inc;
                    if (icnt_inc == len_q) begin
                        state_d = ST_FLUSH;
                        flush_d = 1'b0;
                    end
                end
            end
            ST_FLUSH: begin
                // Two cycles: one for the final accumulate, one to align the output edge.
                flush_d = 1'b1;
                if (flush_q) state_d = ST_OUTPUT;
            end
            ST_OUTPUT: begin
`ifdef IQ_OFFSET_CORR_EN
                if (!ost_q) begin
                    di_d  = 34'(acc_i_q) - 34'(i_offset);
                    dq_d  = 34'(acc_q_q) - 34'(q_offset);
                    ost_d = 1'b1;
                end else begin
                    i_val_d    = sat32(di_q);
                    q_val_d    = sat32(dq_q);
                    ost_d      = 1'b0;
                    iq_valid_d = 1'b1;
                    busy_d     = 1'b0;
                    state_d    = ST_IDLE;
                end
`else
                i_val_d    = 32'(acc_i_q);
                q_val_d    = 32'(acc_q_q);
                iq_valid_d = 1'b1;
                busy_d     = 1'b0;
                state_d    = ST_IDLE;
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk100) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            dly_q      <= '0;
            len_q      <= '0;
            dcnt_q     <= '0;
            icnt_q     <= '0;
            flush_q    <= 1'b0;
            pi_q       <= '0;
            pq_q       <= '0;
            s1v_q      <= 1'b0;
            acc_i_q    <= '0;
            acc_q_q    <= '0;
            busy_q     <= 1'b0;
            iq_valid_q <= 1'b0;
            i_val_q    <= '0;
            q_val_q    <= '0;
            missed_q   <= '0;
`ifdef IQ_OFFSET_CORR_EN
            di_q       <= '0;
            dq_q       <= '0;
            ost_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            dly_q      <= dly_d;
            len_q      <= len_d;
            dcnt_q     <= dcnt_d;
            icnt_q     <= icnt_d;
            flush_q    <= flush_d;
            pi_q       <= pi_d;
            pq_q       <= pq_d;
            s1v_q      <= s1v_d;
            acc_i_q    <= acc_i_d;
            acc_q_q    <= acc_q_d;
            busy_q     <= busy_d;
            iq_valid_q <= iq_valid_d;
            i_val_q    <= i_val_d;
            q_val_q    <= q_val_d;
            missed_q   <= missed_d;
`ifdef IQ_OFFSET_CORR_EN
            di_q       <= di_d;
            dq_q       <= dq_d;
            ost_q      <= ost_d;
`endif
        end
    end

    assign busy        = busy_q;
    assign missed_trig = missed_q;
    assign iq.iq_valid = iq_valid_q;
    assign iq.i_val    = i_val_q;
    assign iq.q_val    = q_val_q;
endmodule
